// File: rtl/armleocpu_decode_pkg.sv
// ---------------------------------------------------------------------------
// armleocpu_decode_pkg
//   Shared encodings for the decode stage. These constants mirror the
//   armleocpu_includes.vh definitions:
//     - ARMLEOCPU_E2F_CMD_* : commands from execute that are forwarded to fetch
//     - ARMLEOCPU_OPCODE_*  : RV32I major opcodes (instr[6:0])
//     - EXCEPTION_CODE_*    : mcause exception codes
//     - decode_state_t      : decode FSM state encoding (also on dbg_state)
// ---------------------------------------------------------------------------
package armleocpu_decode_pkg;

  localparam int ARMLEOCPU_E2F_CMD_WIDTH = 2;

  localparam logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] ARMLEOCPU_E2F_CMD_NONE        = 2'd0;
  localparam logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] ARMLEOCPU_E2F_CMD_BUBBLE_JUMP = 2'd1;
  localparam logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] ARMLEOCPU_E2F_CMD_BRANCHTAKEN = 2'd2;
  localparam logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] ARMLEOCPU_E2F_CMD_FLUSH       = 2'd3;

  localparam logic [6:0] ARMLEOCPU_OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] ARMLEOCPU_OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] ARMLEOCPU_OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] ARMLEOCPU_OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] ARMLEOCPU_OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] ARMLEOCPU_OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] ARMLEOCPU_OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] ARMLEOCPU_OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] ARMLEOCPU_OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] ARMLEOCPU_OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] ARMLEOCPU_OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [31:0] EXCEPTION_CODE_INSTRUCTION_ADDR_MISALIGNED = 32'd0;
  localparam logic [31:0] EXCEPTION_CODE_INSTRUCTION_ACCESS_FAULT    = 32'd1;
  localparam logic [31:0] EXCEPTION_CODE_ILLEGAL_INSTRUCTION         = 32'd2;

  typedef enum logic [1:0] {
    DECODE_EMPTY     = 2'd0,
    DECODE_FULL      = 2'd1,
    DECODE_TRAP_WAIT = 2'd2
  } decode_state_t;

endpackage

// File: rtl/armleocpu_decode_illegal_detect.sv
// ---------------------------------------------------------------------------
// armleocpu_decode_illegal_detect
//   Purely combinational opcode legality check. Flags an instruction whose
//   low two bits are not 2'b11 (compressed / non-32-bit) or whose major
//   opcode is not one of the RV32I base opcodes handled by this core.
//   Only compiled when ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN is defined.
//
//   Ports:
//     i_opcode  in  7 : instr[6:0]
//     o_illegal out 1 : 1 = instruction must trap as illegal
// ---------------------------------------------------------------------------
`ifdef ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN
module armleocpu_decode_illegal_detect
  import armleocpu_decode_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_illegal
);

  logic w_known_opcode;

  always_comb begin
    w_known_opcode = 1'b0;
    case (i_opcode)
      ARMLEOCPU_OPCODE_LUI,
      ARMLEOCPU_OPCODE_AUIPC,
      ARMLEOCPU_OPCODE_JAL,
      ARMLEOCPU_OPCODE_JALR,
      ARMLEOCPU_OPCODE_BRANCH,
      ARMLEOCPU_OPCODE_LOAD,
      ARMLEOCPU_OPCODE_STORE,
      ARMLEOCPU_OPCODE_OP_IMM,
      ARMLEOCPU_OPCODE_OP,
      ARMLEOCPU_OPCODE_MISC_MEM,
      ARMLEOCPU_OPCODE_SYSTEM: w_known_opcode = 1'b1;
      default:                 w_known_opcode = 1'b0;
    endcase
  end

  // Every base opcode ends in 2'b11, so the explicit size check is redundant
  // with the table but keeps the intent obvious.
  assign o_illegal = (i_opcode[1:0] != 2'b11) || !w_known_opcode;

endmodule
`endif

// File: rtl/armleocpu_decode.sv
// ---------------------------------------------------------------------------
// armleocpu_decode
//   Single-entry decode stage between fetch and execute. Holds at most one
//   instruction, forwards execute's redirect commands to fetch with zero
//   latency, and parks trapping instructions (fetch fault, interrupt,
//   optionally illegal opcode) in TRAP_WAIT until execute issues a
//   BUBBLE_JUMP to the trap vector.
//
//   Handshake: an instruction moves fetch->decode on a rising edge where
//   f2d_instr_valid=1 and d2f_ready=1. decode->execute: d2e_instr_valid=1
//   presents an instruction; it is consumed on an edge with e2d_ready=1, and
//   all d2e_* outputs stay stable while e2d_ready=0.
//
//   Optional feature macro: ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN enables the
//   illegal-opcode check; otherwise d2e_illegal_instr is tied to 0.
//
//   Ports:
//     clk, rst_n                       clock, synchronous active-low reset
//     f2d_*  in                        instruction + trap tags from fetch
//     d2f_ready, d2f_cmd,
//     d2f_jump_target  out             handshake / redirect to fetch
//     d2e_*  out                       registered instruction + tags to execute
//     e2d_ready, e2d_cmd,
//     e2d_jump_target  in              ready / redirect from execute
//     rs1_addr, rs2_addr out           register-file read addresses
//     dbg_state out                    current FSM state (decode_state_t)
// ---------------------------------------------------------------------------
module armleocpu_decode
  import armleocpu_decode_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,

  input  logic                               f2d_instr_valid,
  input  logic [31:0]                        f2d_instr,
  input  logic [31:0]                        f2d_pc,
  input  logic                               f2d_instr_fetch_exception,
  input  logic [31:0]                        f2d_instr_fetch_exception_cause,
  input  logic                               f2d_interrupt_pending,

  output logic                               d2f_ready,
  output logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] d2f_cmd,
  output logic [31:0]                        d2f_jump_target,

  output logic                               d2e_instr_valid,
  output logic [31:0]                        d2e_instr,
  output logic [31:0]                        d2e_pc,
  output logic                               d2e_instr_fetch_exception,
  output logic [31:0]                        d2e_instr_fetch_exception_cause,
  output logic                               d2e_interrupt_pending,
  output logic                               d2e_illegal_instr,

  input  logic                               e2d_ready,
  input  logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] e2d_cmd,
  input  logic [31:0]                        e2d_jump_target,

  output logic [4:0]                         rs1_addr,
  output logic [4:0]                         rs2_addr,

  output logic [1:0]                         dbg_state
);

  decode_state_t r_state;
  logic          r_d2e_instr_valid;
  logic [31:0]   r_d2e_instr;
  logic [31:0]   r_d2e_pc;
  logic          r_d2e_instr_fetch_exception;
  logic [31:0]   r_d2e_instr_fetch_exception_cause;
  logic          r_d2e_interrupt_pending;

  logic          w_accept;
  logic          w_load;
  logic          w_illegal;
  logic          w_trap_tag;
  logic          w_cmd_none;
  logic          w_cmd_bubble_jump;

  assign w_cmd_none        = (e2d_cmd == ARMLEOCPU_E2F_CMD_NONE);
  assign w_cmd_bubble_jump = (e2d_cmd == ARMLEOCPU_E2F_CMD_BUBBLE_JUMP);

  // The slot can take a new instruction when empty, or when the held one is
  // consumed this cycle without a redirect (a redirect makes the incoming
  // instruction wrong-path).
  assign w_accept = (r_state == DECODE_EMPTY) ||
                    ((r_state == DECODE_FULL) && e2d_ready && w_cmd_none);
  assign w_load   = w_accept && f2d_instr_valid;

  // In TRAP_WAIT fetch is drained (ready=1) but whatever it sends is dropped;
  // execute will redirect it to the trap vector.
  assign d2f_ready       = w_accept || (r_state == DECODE_TRAP_WAIT);
  assign d2f_cmd         = e2d_cmd;
  assign d2f_jump_target = e2d_jump_target;

`ifdef ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN
  logic r_d2e_illegal_instr;

  armleocpu_decode_illegal_detect u_illegal_detect (
    .i_opcode  (f2d_instr[6:0]),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d2e_illegal_instr <= 1'b0;
    end else if (w_load) begin
      r_d2e_illegal_instr <= w_illegal;
    end
  end

  assign d2e_illegal_instr = r_d2e_illegal_instr;
`else
  assign w_illegal         = 1'b0;
  assign d2e_illegal_instr = 1'b0;
`endif

  assign w_trap_tag = f2d_instr_fetch_exception || f2d_interrupt_pending || w_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state                           <= DECODE_EMPTY;
      r_d2e_instr_valid                 <= 1'b0;
      r_d2e_instr                       <= 32'd0;
      r_d2e_pc                          <= 32'd0;
      r_d2e_instr_fetch_exception       <= 1'b0;
      r_d2e_instr_fetch_exception_cause <= 32'd0;
      r_d2e_interrupt_pending           <= 1'b0;
    end else if (w_accept) begin
      if (f2d_instr_valid) begin
        r_d2e_instr_valid                 <= 1'b1;
        r_d2e_instr                       <= f2d_instr;
        r_d2e_pc                          <= f2d_pc;
        r_d2e_instr_fetch_exception       <= f2d_instr_fetch_exception;
        r_d2e_instr_fetch_exception_cause <= f2d_instr_fetch_exception_cause;
        r_d2e_interrupt_pending           <= f2d_interrupt_pending;
        r_state <= w_trap_tag ? DECODE_TRAP_WAIT : DECODE_FULL;
      end else begin
        r_d2e_instr_valid <= 1'b0;
        r_state           <= DECODE_EMPTY;
      end
    end else if (r_state == DECODE_FULL) begin
      // Not accepting while FULL means either a stall (hold everything) or a
      // consumed instruction with a redirect (kill the wrong-path fetch).
      if (e2d_ready) begin
        r_d2e_instr_valid <= 1'b0;
        r_state           <= DECODE_EMPTY;
      end
    end else if (r_state == DECODE_TRAP_WAIT) begin
      if (e2d_ready || w_cmd_bubble_jump) begin
        r_d2e_instr_valid <= 1'b0;
      end
      if (w_cmd_bubble_jump) begin
        r_state <= DECODE_EMPTY;
      end
    end else begin
      // Unused encoding: recover to a clean empty slot.
      r_d2e_instr_valid <= 1'b0;
      r_state           <= DECODE_EMPTY;
    end
  end

  // Addresses track whatever d2e_instr will hold next cycle, so register data
  // from the synchronous file lines up with the presented instruction.
  assign rs1_addr = w_accept ? f2d_instr[19:15] : r_d2e_instr[19:15];
  assign rs2_addr = w_accept ? f2d_instr[24:20] : r_d2e_instr[24:20];

  assign d2e_instr_valid                 = r_d2e_instr_valid;
  assign d2e_instr                       = r_d2e_instr;
  assign d2e_pc                          = r_d2e_pc;
  assign d2e_instr_fetch_exception       = r_d2e_instr_fetch_exception;
  assign d2e_instr_fetch_exception_cause = r_d2e_instr_fetch_exception_cause;
  assign d2e_interrupt_pending           = r_d2e_interrupt_pending;
  assign dbg_state                       = r_state;

endmodule
